// File: rtl/rom_load_sequencer.sv
// ROM load sequencer: owns the ROM write port; clears the ROM, then streams
//   buffered loader bytes into it and finally releases the CPU from reset.
// Ports: clk_74a/reset_n; load_start/load_done host pulses; loader_wr_* byte
//   stream in; mem_* registered ROM write port; cpu_reset_n, busy, overflow.
// Optional: define ROM_CLEAR_EN to include the CLEAR state and clear engine;
//   without it load_start goes straight to LOAD.
module rom_load_sequencer #(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] CLEAR_VALUE = 8'hFF
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic        load_done,
  input  logic        loader_wr_en,
  input  logic [14:0] loader_wr_addr,
  input  logic [7:0]  loader_wr_data,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef logic [AW:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t DEPTH_P = ptr_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ROM_CLEAR_EN
    ST_CLEAR = 2'd1,
`endif
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

`ifdef ROM_CLEAR_EN
  localparam state_t ST_START = ST_CLEAR;
`else
  localparam state_t ST_START = ST_LOAD;
`endif

  state_t      state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        done_pending_q, done_pending_d;
  logic        overflow_q, overflow_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        fifo_push;
  logic [22:0] fifo_mem [FIFO_DEPTH];
  ptr_t        fifo_cnt;
  logic        fifo_empty, fifo_full;
  logic        load_exit, restart;

`ifdef ROM_CLEAR_EN
  logic [14:0] clr_cnt_q, clr_cnt_d;
`else
  logic        unused_clear_value;
  assign unused_clear_value = ^CLEAR_VALUE;
`endif

  // Extra pointer bit distinguishes full from empty when indices match.
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_P);

  // A load_done arriving this very cycle counts, so the exit is not delayed.
  assign load_exit = (state_q == ST_LOAD) && (done_pending_q || load_done) &&
                     fifo_empty && !loader_wr_en;
  assign restart   = load_start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

  // State register
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: if (load_start) state_d = ST_START;
`ifdef ROM_CLEAR_EN
      ST_CLEAR:        if (clr_cnt_q == 15'h7FFF) state_d = ST_LOAD;
`endif
      ST_LOAD:         if (load_exit) state_d = ST_RUN;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    done_pending_d = done_pending_q;
    overflow_d     = overflow_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    cpu_reset_n_d  = 1'b0;
    fifo_push      = 1'b0;
`ifdef ROM_CLEAR_EN
    clr_cnt_d      = clr_cnt_q;
`endif
    case (state_q)
`ifdef ROM_CLEAR_EN
      ST_CLEAR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = clr_cnt_q;
        mem_data_d = CLEAR_VALUE;
        clr_cnt_d  = clr_cnt_q + 15'd1;  // wraps to 0 after the last address
        if (loader_wr_en) begin
          if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            fifo_push = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
          end
        end
        if (load_done) done_pending_d = 1'b1;
      end
`endif
      ST_LOAD: begin
        if (!fifo_empty) begin
          mem_we_d                 = 1'b1;
          {mem_addr_d, mem_data_d} = fifo_mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d                 = rd_ptr_q + PTR_ONE;
          // The pop frees a slot this cycle, so a simultaneous push never drops.
          if (loader_wr_en) begin
            fifo_push = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
          end
        end else if (loader_wr_en) begin
          // Empty buffer: bypass straight to the ROM port for 1-cycle latency.
          mem_we_d   = 1'b1;
          mem_addr_d = loader_wr_addr;
          mem_data_d = loader_wr_data;
        end
        done_pending_d = load_exit ? 1'b0 : (done_pending_q | load_done);
      end
      ST_RUN:  cpu_reset_n_d = 1'b1;
      default: ;
    endcase
    if (restart) begin
      cpu_reset_n_d  = 1'b0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      done_pending_d = 1'b0;
      overflow_d     = 1'b0;
`ifdef ROM_CLEAR_EN
      clr_cnt_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      done_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      cpu_reset_n_q  <= 1'b0;
`ifdef ROM_CLEAR_EN
      clr_cnt_q      <= '0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      done_pending_q <= done_pending_d;
      overflow_q     <= overflow_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      cpu_reset_n_q  <= cpu_reset_n_d;
`ifdef ROM_CLEAR_EN
      clr_cnt_q      <= clr_cnt_d;
`endif
    end
  end

  // Buffer storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk_74a) begin
    if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= {loader_wr_addr, loader_wr_data};
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign overflow    = overflow_q;
`ifdef ROM_CLEAR_EN
  assign busy = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
`else
  assign busy = (state_q == ST_LOAD);
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: directed host/loader stimulus, a queue-based
//   model of the sequencer compared every cycle, plus literal spot checks.
// Works with or without ROM_CLEAR_EN defined.
module tb_rom_load_sequencer;

  localparam int DEPTH = 16;
`ifdef ROM_CLEAR_EN
  localparam int START_MODE = 1;
  localparam int BASE       = 32768;
`else
  localparam int START_MODE = 2;
  localparam int BASE       = 0;
`endif

  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic        load_start, load_done, loader_wr_en;
  logic [14:0] loader_wr_addr;
  logic [7:0]  loader_wr_data;
  logic        mem_we, cpu_reset_n, busy, overflow;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;

  rom_load_sequencer #(.FIFO_DEPTH(DEPTH), .CLEAR_VALUE(8'hFF)) dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .load_start(load_start), .load_done(load_done),
    .loader_wr_en(loader_wr_en), .loader_wr_addr(loader_wr_addr),
    .loader_wr_data(loader_wr_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .overflow(overflow)
  );

  always #5 clk_74a = ~clk_74a;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;
  logic [22:0] act_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- model: mode 0 idle, 1 clear, 2 load, 3 run ----------------
  int          m_mode = 0;
  int          m_cnt  = 0;
  logic [22:0] m_q[$];
  bit          m_done = 1'b0, m_ovf = 1'b0;
  logic        exp_we = 1'b0, exp_cpu = 1'b0;
  logic [14:0] exp_addr = '0;
  logic [7:0]  exp_data = '0;

  task automatic m_reset();
    m_mode = 0; m_cnt = 0; m_q.delete(); m_done = 0; m_ovf = 0;
    exp_we = 0; exp_cpu = 0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic m_begin_load();
    m_mode = START_MODE; m_cnt = 0; m_q.delete(); m_done = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    logic [22:0] e;
    bit was_empty, d;
    exp_we  = 0;
    exp_cpu = 0;
    case (m_mode)
      0: if (load_start) m_begin_load();
      1: begin
        exp_we = 1; exp_addr = m_cnt[14:0]; exp_data = 8'hFF;
        if (loader_wr_en) begin
          if (m_q.size() < DEPTH) m_q.push_back({loader_wr_addr, loader_wr_data});
          else m_ovf = 1;
        end
        if (load_done) m_done = 1;
        m_cnt++;
        if (m_cnt == 32768) m_mode = 2;
      end
      2: begin
        was_empty = (m_q.size() == 0);
        d = m_done || load_done;
        if (!was_empty) begin
          e = m_q.pop_front();
          exp_we = 1; exp_addr = e[22:8]; exp_data = e[7:0];
          if (loader_wr_en) m_q.push_back({loader_wr_addr, loader_wr_data});
        end else if (loader_wr_en) begin
          exp_we = 1; exp_addr = loader_wr_addr; exp_data = loader_wr_data;
        end
        if (d && was_empty && !loader_wr_en) begin
          m_mode = 3; m_done = 0;
        end else m_done = d;
      end
      default: begin
        if (load_start) m_begin_load();
        else exp_cpu = 1;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk_74a or negedge reset_n);
    if (!reset_n) m_reset();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_74a);
    if (mem_we === 1'b1) act_log.push_back({mem_addr, mem_data});
    if (cmp_en) begin
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_data", mem_data, exp_data);
      chk("cpu_reset_n", cpu_reset_n, exp_cpu);
      chk("busy", busy, (m_mode == 1 || m_mode == 2));
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic step();
    @(posedge clk_74a);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    load_start = 0; load_done = 0; loader_wr_en = 0;
    loader_wr_addr = '0; loader_wr_data = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk_74a);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    step(); step();
    reset_n = 1'b1;

    // IDLE ignores loader writes and load_done
    loader_wr_en = 1; loader_wr_addr = 15'h0123; loader_wr_data = 8'h55; load_done = 1;
    step();
    loader_wr_en = 0; load_done = 0;
    @(negedge clk_74a);
    chk("idle_we", mem_we, 0);
    chk("idle_busy", busy, 0);
    act_log.delete();

    // First load: three bytes sent right after load_start
    step(); load_start = 1;
    step(); load_start = 0;
    loader_wr_en = 1; loader_wr_addr = 15'h0000; loader_wr_data = 8'h0C;
    @(negedge clk_74a);
    chk("start_busy", busy, 1);
    step(); loader_wr_addr = 15'h0001; loader_wr_data = 8'h94;
    step(); loader_wr_addr = 15'h7FFF; loader_wr_data = 8'h3A;
    step(); loader_wr_en = 0; load_start = 1;  // ignored while busy
    step(); load_start = 0;
    repeat (BASE + 10) step();
    @(negedge clk_74a);
    chk("l1_count", act_log.size(), BASE + 3);
`ifdef ROM_CLEAR_EN
    chk("clr_first", act_log[0], {15'h0000, 8'hFF});
    chk("clr_last", act_log[32767], {15'h7FFF, 8'hFF});
`endif
    chk("l1_w0", act_log[BASE], {15'h0000, 8'h0C});
    chk("l1_w1", act_log[BASE + 1], {15'h0001, 8'h94});
    chk("l1_w2", act_log[BASE + 2], {15'h7FFF, 8'h3A});
    chk("l1_ovf", overflow, 0);

    // Empty buffer in LOAD: 1-cycle write latency, then load_done -> RUN
    step();
    loader_wr_en = 1; loader_wr_addr = 15'h0100; loader_wr_data = 8'hAB;
    step();
    loader_wr_en = 0; load_done = 1;
    @(negedge clk_74a);
    chk("n1_we", mem_we, 1);
    chk("n1_addr", mem_addr, 15'h0100);
    chk("n1_data", mem_data, 8'hAB);
    chk("n1_cpu", cpu_reset_n, 0);
    step(); load_done = 0;
    @(negedge clk_74a);
    chk("n2_cpu", cpu_reset_n, 0);
    chk("n2_busy", busy, 0);
    step();
    @(negedge clk_74a);
    chk("n3_cpu", cpu_reset_n, 1);

    // RUN ignores loader writes
    for (int i = 0; i < 3; i++) begin
      step(); loader_wr_en = 1; loader_wr_addr = 15'(16'h0400 + i); loader_wr_data = 8'(i);
    end
    step(); loader_wr_en = 0;
    @(negedge clk_74a);
    chk("run_we", mem_we, 0);
    chk("run_cpu", cpu_reset_n, 1);

    // Restart from RUN with simultaneous load_done, then 17 bytes
    step(); load_start = 1; load_done = 1;
    step(); load_start = 0; load_done = 0;
    act_log.delete();
    loader_wr_en = 1; loader_wr_addr = 15'h0200; loader_wr_data = 8'd3;
    @(negedge clk_74a);
    chk("rs_cpu", cpu_reset_n, 0);
    chk("rs_busy", busy, 1);
    for (int i = 1; i < 17; i++) begin
      step();
      loader_wr_addr = 15'(16'h0200 + i); loader_wr_data = 8'(i * 7 + 3);
`ifdef ROM_CLEAR_EN
      if (i == 1) begin
        @(negedge clk_74a);
        chk("rs_clr_we", mem_we, 1);
        chk("rs_clr_addr", mem_addr, 15'h0000);
        chk("rs_clr_data", mem_data, 8'hFF);
      end
`endif
    end
    step(); loader_wr_en = 0;
    repeat (BASE + 24) step();
    @(negedge clk_74a);
`ifdef ROM_CLEAR_EN
    chk("ovf_count", act_log.size(), BASE + 16);
    chk("ovf_last", act_log[act_log.size() - 1], {15'h020F, 8'h6C});
    chk("ovf_sticky", overflow, 1);
`else
    chk("byp_count", act_log.size(), 17);
    chk("byp_last", act_log[act_log.size() - 1], {15'h0210, 8'h73});
    chk("byp_ovf", overflow, 0);
`endif

    // Reset mid-LOAD
    loader_wr_en = 1; loader_wr_addr = 15'h0300; loader_wr_data = 8'h77;
    step(); loader_wr_en = 0; reset_n = 1'b0;
    @(negedge clk_74a);
    chk("rl_we", mem_we, 0);
    chk("rl_busy", busy, 0);
    chk("rl_ovf", overflow, 0);
    step(); step();
    reset_n = 1'b1;
    loader_wr_en = 1; loader_wr_addr = 15'h0301; loader_wr_data = 8'h11;
    step(); loader_wr_en = 0;
    @(negedge clk_74a);
    chk("rel_we", mem_we, 0);
    step(); load_start = 1;
    step(); load_start = 0;
    repeat (5) step();
    @(negedge clk_74a);
`ifdef ROM_CLEAR_EN
    chk("l3_we", mem_we, 1);
    repeat (40) step();
    reset_n = 1'b0;
    @(negedge clk_74a);
    chk("rc_we", mem_we, 0);
    chk("rc_busy", busy, 0);
    step(); reset_n = 1'b1;
    step();
    @(negedge clk_74a);
    chk("rc_rel_we", mem_we, 0);
`else
    chk("l3_we", mem_we, 0);
    chk("l3_busy", busy, 1);
`endif
    step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
ROM_LOAD_SEQUENCER -- requirements
Module: rom_load_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, loader write buffer entries (power of two, 2..64).
REQ-002 SHALL have parameter CLEAR_VALUE, default 8'hFF, byte written to every ROM location during clear.
REQ-003 SHALL have port clk_74a  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_start  input  1  single-cycle pulse, host begins a ROM load.
REQ-006 SHALL have port load_done  input  1  single-cycle pulse, host finished sending ROM data.
REQ-007 SHALL have port loader_wr_en  input  1  decoded ROM byte valid, from hex loader.
REQ-008 SHALL have port loader_wr_addr  input  15  ROM byte address.
REQ-009 SHALL have port loader_wr_data  input  8  ROM byte.
REQ-010 SHALL have port mem_we  output  1  ROM write strobe, registered.
REQ-011 SHALL have port mem_addr  output  15  ROM write address, registered.
REQ-012 SHALL have port mem_data  output  8  ROM write data, registered.
REQ-013 SHALL have port cpu_reset_n  output  1  active-low CPU reset, registered.
REQ-014 SHALL have port busy  output  1  high in CLEAR or LOAD.
REQ-015 SHALL have port overflow  output  1  sticky, a loader write was dropped.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, RUN; sole owner of the ROM write port.
REQ-017 IDLE: cpu_reset_n=0; load_start -> CLEAR; loader writes ignored.
REQ-018 CLEAR: 15-bit counter from 0 to 32767, one mem_we per cycle, mem_addr=counter, mem_data=CLEAR_VALUE; after addr 32767 written -> LOAD next cycle (32768 cycles total).
REQ-019 CLEAR: loader_wr_en pushes {addr,data} into FIFO; push when full drops the byte and sets overflow.
REQ-020 LOAD: pop one FIFO entry per cycle onto mem_*; push and pop in same cycle both take effect; a push into empty FIFO SHALL appear on mem_we exactly 1 cycle later.
REQ-021 FIFO full/empty by (depth+1)-bit pointer difference; pointers wrap modulo FIFO_DEPTH without loss.
REQ-022 load_done in CLEAR or LOAD SHALL be latched as done_pending; LOAD -> RUN when done_pending and FIFO empty and no push that cycle.
REQ-023 RUN: cpu_reset_n=1 starting the cycle after entry; loader writes ignored; mem_we=0.
REQ-024 load_start in RUN -> CLEAR, cpu_reset_n=0 next cycle, overflow and done_pending cleared, FIFO flushed.
REQ-025 load_start in CLEAR or LOAD SHALL be ignored.
REQ-026 load_done in IDLE or RUN SHALL be ignored.
REQ-027 load_start and load_done in the same cycle in RUN: restart per REQ-024, load_done discarded.
REQ-028 mem_we SHALL be 0 in IDLE and RUN and on LOAD cycles with FIFO empty; mem_addr/mem_data hold last value when mem_we=0.
REQ-029 busy combinational from state; no other combinational outputs.

Reset
REQ-030 reset_n low SHALL asynchronously force: state IDLE, mem_we=0, mem_addr=0, mem_data=0, cpu_reset_n=0, overflow=0, done_pending=0, FIFO pointers=0, clear counter=0.
REQ-031 reset mid-CLEAR or mid-LOAD SHALL abandon the operation; no write issued on the first edge after release.
REQ-032 FIFO storage array SHALL not require reset.

Configuration
REQ-033 Macro ROM_CLEAR_EN SHALL gate the clear engine.
REQ-034 With ROM_CLEAR_EN defined: behaviour per REQ-018/019.
REQ-035 Without ROM_CLEAR_EN: CLEAR state and counter absent; load_start goes directly to LOAD; ROM contents outside loaded addresses undefined; all other requirements unchanged.

Verification
REQ-036 Reset release, load_start -> mem_we high 32768 consecutive cycles, addr 0..32767, data 8'hFF, then LOAD (ROM_CLEAR_EN).
REQ-037 3 loader writes (0x0000/0x0C, 0x0001/0x94, 0x7FFF/0x3A) during CLEAR -> written in order in first 3 LOAD cycles after clear, overflow=0.
REQ-038 17 loader writes during CLEAR with FIFO_DEPTH=16 -> first 16 written in LOAD, 17th dropped, overflow=1 until next load_start.
REQ-039 In LOAD, empty FIFO, write 0x0100/0xAB at cycle N -> mem_we=1, mem_addr=0x0100, mem_data=0xAB at cycle N+1; load_done at N+1 -> RUN, cpu_reset_n=1 at N+3.
REQ-040 load_start in RUN -> cpu_reset_n=0 next cycle, clear restarts at addr 0; reset_n pulsed low mid-LOAD -> IDLE, mem_we=0, FIFO empty.
